// File: rtl/shift_sched_pkg.sv
// Shared constants for the rotate-register scheduler: FSM state
// encoding and rotate-direction encoding.
package shift_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rot_reg.sv
// WIDTH-bit rotate register. A load takes priority over a shift step;
// each shift step rotates by exactly one bit in the selected direction.
module rot_reg
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_r;

  // Hold, load, or rotate the word by one bit per enabled cycle.
  always_ff @(posedge clk) begin
    if (rest) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_RIGHT) begin
        data_r <= {data_r[0], data_r[WIDTH-1:1]};
      end else begin
        data_r <= {data_r[WIDTH-2:0], data_r[WIDTH-1]};
      end
    end else begin
      data_r <= data_r;
    end
  end

  assign q = data_r;

endmodule

// File: rtl/shift_scheduler.sv
// Round-robin front end for the rotate register: accepts one request at a
// time from two clients, steps the rotator amt times, then pulses the
// result tagged with the owning requester.
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_dir,
  input  logic [CNT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_dir,
  input  logic [CNT_W-1:0] req1_amt,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] AMT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] AMT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] remain_r;
  logic             dir_r;
  logic             ptr_r;      // requester that wins when both are valid
  logic             res_id_r;
  logic             res_valid_r;
  logic             busy_r;
  logic             grant_s;
  logic             accept_s;
  logic             shift_en_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_dir_s;
  logic [CNT_W-1:0] sel_amt_s;

  // Pick the requester to serve: a lone valid wins, contention uses the pointer.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ptr_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign req0_ready = (state_r == ST_IDLE) && req0_valid && (grant_s == 1'b0);
  assign req1_ready = (state_r == ST_IDLE) && req1_valid && (grant_s == 1'b1);
  assign accept_s   = req0_ready || req1_ready;
  assign shift_en_s = (state_r == ST_SHIFT);

  // Steer the granted requester's payload toward the rotator and latches.
  always_comb begin
    sel_data_s = req0_data;
    sel_dir_s  = req0_dir;
    sel_amt_s  = req0_amt;
    if (grant_s) begin
      sel_data_s = req1_data;
      sel_dir_s  = req1_dir;
      sel_amt_s  = req1_amt;
    end else begin
      sel_data_s = req0_data;
      sel_dir_s  = req0_dir;
      sel_amt_s  = req0_amt;
    end
  end

  // Sequence IDLE -> SHIFT (amt steps) -> DONE; a zero amount skips SHIFT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (sel_amt_s != AMT_ZERO) ? ST_SHIFT : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (remain_r == AMT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, step counter, latched request fields and registered status outputs.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_r     <= ST_IDLE;
      remain_r    <= AMT_ZERO;
      dir_r       <= DIR_LEFT;
      ptr_r       <= 1'b0;
      res_id_r    <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      res_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (accept_s) begin
        remain_r <= sel_amt_s;
        dir_r    <= sel_dir_s;
        res_id_r <= grant_s;
        ptr_r    <= ~grant_s;
      end else if (shift_en_s) begin
        remain_r <= remain_r - AMT_ONE;
      end else begin
        remain_r <= remain_r;
      end
    end
  end

  rot_reg #(
    .WIDTH (WIDTH)
  ) u_rot_reg (
    .clk       (clk),
    .rest      (rest),
    .load      (accept_s),
    .load_data (sel_data_s),
    .shift_en  (shift_en_s),
    .dir       (dir_r),
    .q         (res_data)
  );

  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed self-checking bench for shift_scheduler.
module tb_shift_scheduler;

  logic       clk;
  logic       rest;
  logic       req0_valid, req0_ready, req0_dir;
  logic [7:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [7:0] req1_data;
  logic [2:0] req1_amt;
  logic       res_valid, res_id, busy;
  logic [7:0] res_data;

  int tests = 0;
  int fails = 0;

  shift_scheduler #(.WIDTH(8), .CNT_W(3)) dut (
    .clk        (clk),
    .rest       (rest),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_dir   (req0_dir),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_dir   (req1_dir),
    .req1_amt   (req1_amt),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_data   (res_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, confirm it is ready, let it transfer, then drop valid.
  task automatic issue(input logic id, input logic [7:0] d, input logic dr, input logic [2:0] a);
    @(negedge clk);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_data = d; req0_dir = dr; req0_amt = a;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_dir = dr; req1_amt = a;
    end
    #1;
    chk("ready_granted", (id ? req1_ready : req0_ready), 32'd1);
    chk("ready_other",   (id ? req0_ready : req1_ready), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called right after an acceptance edge: check latency, busy span, result and tag.
  task automatic wait_result(input string tag, input logic exp_id, input logic [7:0] exp_data,
                             input int amt);
    int lat   = 0;
    int nbusy = 0;
    logic [7:0] got_data = 8'h00;
    logic       got_id   = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (res_valid === 1'b1) begin
        lat      = i;
        got_data = res_data;
        got_id   = res_id;
      end
    end
    chk({tag, "_latency"}, lat, amt + 1);
    chk({tag, "_busy_cycles"}, nbusy, amt + 1);
    chk({tag, "_data"}, got_data, exp_data);
    chk({tag, "_id"}, got_id, exp_id);
    @(negedge clk);
    chk({tag, "_pulse_end"}, res_valid, 32'd0);
    chk({tag, "_busy_end"}, busy, 32'd0);
    chk({tag, "_data_hold"}, res_data, exp_data);
  endtask

  initial begin
    int seen;
    rest = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_dir = 1'b0; req0_amt = 3'd0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_dir = 1'b0; req1_amt = 3'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_res_valid", res_valid, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", res_id, 32'd0);
    chk("rst_busy", busy, 32'd0);
    rest = 1'b0;

    // Left rotate: 11110000 rotl 3 = 10000111
    issue(1'b0, 8'b11110000, 1'b0, 3'd3);
    wait_result("left3", 1'b0, 8'b10000111, 3);

    // Right rotate: 00000001 rotr 1 = 10000000
    issue(1'b1, 8'b00000001, 1'b1, 3'd1);
    wait_result("right1", 1'b1, 8'b10000000, 1);

    // Contention: pointer now favours req0, so req0 then req1
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h0F; req0_dir = 1'b0; req0_amt = 3'd2;
    req1_valid = 1'b1; req1_data = 8'h81; req1_dir = 1'b1; req1_amt = 3'd1;
    #1;
    chk("cont1_ready0", req0_ready, 32'd1);
    chk("cont1_ready1", req1_ready, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    chk("cont_busy_ready1", req1_ready, 32'd0);
    wait_result("cont_req0", 1'b0, 8'h3C, 2);
    #1;
    chk("cont2_ready0", req0_ready, 32'd0);
    chk("cont2_ready1", req1_ready, 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_result("cont_req1", 1'b1, 8'hC0, 1);

    // Zero amount: word passes through unchanged
    issue(1'b0, 8'hA5, 1'b0, 3'd0);
    wait_result("zero", 1'b0, 8'hA5, 0);

    // Maximum amount: 10100101 rotr 7 = 01001011
    issue(1'b1, 8'b10100101, 1'b1, 3'd7);
    wait_result("max7", 1'b1, 8'b01001011, 7);

    // Reset mid-operation: req0 amt 5 leaves pointer on req1 until reset
    issue(1'b0, 8'h3C, 1'b0, 3'd5);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_before", busy, 32'd1);
    rest = 1'b1;
    @(negedge clk);
    chk("midrst_res_valid", res_valid, 32'd0);
    chk("midrst_res_data", res_data, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    rest = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen++;
    end
    chk("midrst_no_pulse", seen, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("midrst_ptr_ready0", req0_ready, 32'd1);
    chk("midrst_ptr_ready1", req1_ready, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
